// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with load-use stall, bubble insertion, branch flush and WB bypass.
// Latency: one cycle ID->EX; a load-use hazard costs exactly one bubble.
// Backpressure: Stall (combinational from ID_EX state) holds PC and IF/ID; Flush overrides it.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   IF_ID_RegisterRs/Rt, ID_*       decoded instruction fields, operands and control from ID
//   Flush                           squash the instruction currently in ID
//   MEM_WB_RegWrite/RegisterRd,
//   WB_Data                         same-cycle register-file write, bypassed into captured operands
//   Stall                           load-use hazard detected and not overridden by Flush
//   ID_EX_*                         registered copies of the ID inputs (zero when a bubble)
//   StallCount, FlushCount          saturating event counters

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] IF_ID_RegisterRs,
    input  logic [REG_AW-1:0] IF_ID_RegisterRt,
    input  logic [REG_AW-1:0] ID_RegisterRd,
    input  logic              ID_UsesRt,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_ALUSrc,
    input  logic [3:0]        ID_ALUOp,
    input  logic              Flush,
    input  logic              MEM_WB_RegWrite,
    input  logic [REG_AW-1:0] MEM_WB_RegisterRd,
    input  logic [DATA_W-1:0] WB_Data,
    output logic              Stall,
    output logic [REG_AW-1:0] ID_EX_RegisterRs,
    output logic [REG_AW-1:0] ID_EX_RegisterRt,
    output logic [REG_AW-1:0] ID_EX_RegisterRd,
    output logic              ID_EX_UsesRt,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemtoReg,
    output logic              ID_EX_ALUSrc,
    output logic [3:0]        ID_EX_ALUOp,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              uses_rt;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [3:0]        alu_op;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic haz;
    logic byp_rs;
    logic byp_rt;

    always_comb begin
        // The load in EX cannot supply its value until MEM, so a dependent
        // instruction in ID must wait one cycle. $0 is hard-wired, never a hazard.
        haz = ex_q.mem_read && (ex_q.rt != '0) &&
              ((ex_q.rt == IF_ID_RegisterRs) ||
               (ID_UsesRt && (ex_q.rt == IF_ID_RegisterRt)));
        // A taken branch discards the dependent instruction anyway, so no stall.
        Stall = haz && !Flush;

        // The register file is read before the WB write lands, so forward it here.
        byp_rs = MEM_WB_RegWrite && (MEM_WB_RegisterRd != '0) &&
                 (MEM_WB_RegisterRd == IF_ID_RegisterRs);
        byp_rt = MEM_WB_RegWrite && (MEM_WB_RegisterRd != '0) &&
                 (MEM_WB_RegisterRd == IF_ID_RegisterRt);

        ex_d = '0;
        if (!(Flush || haz)) begin
            ex_d.rs         = IF_ID_RegisterRs;
            ex_d.rt         = IF_ID_RegisterRt;
            ex_d.rd         = ID_RegisterRd;
            ex_d.uses_rt    = ID_UsesRt;
            ex_d.rd1        = byp_rs ? WB_Data : ID_ReadData1;
            ex_d.rd2        = byp_rt ? WB_Data : ID_ReadData2;
            ex_d.imm        = ID_Imm;
            ex_d.reg_write  = ID_RegWrite;
            ex_d.mem_read   = ID_MemRead;
            ex_d.mem_write  = ID_MemWrite;
            ex_d.mem_to_reg = ID_MemtoReg;
            ex_d.alu_src    = ID_ALUSrc;
            ex_d.alu_op     = ID_ALUOp;
        end

        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (Flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ID_EX_RegisterRs = ex_q.rs;
    assign ID_EX_RegisterRt = ex_q.rt;
    assign ID_EX_RegisterRd = ex_q.rd;
    assign ID_EX_UsesRt     = ex_q.uses_rt;
    assign ID_EX_ReadData1  = ex_q.rd1;
    assign ID_EX_ReadData2  = ex_q.rd2;
    assign ID_EX_Imm        = ex_q.imm;
    assign ID_EX_RegWrite   = ex_q.reg_write;
    assign ID_EX_MemRead    = ex_q.mem_read;
    assign ID_EX_MemWrite   = ex_q.mem_write;
    assign ID_EX_MemtoReg   = ex_q.mem_to_reg;
    assign ID_EX_ALUSrc     = ex_q.alu_src;
    assign ID_EX_ALUOp      = ex_q.alu_op;
    assign StallCount       = stall_cnt_q;
    assign FlushCount       = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose: directed, table-driven check of id_ex_stage hazard, flush, bypass and counter behaviour.
// Latency: each vector drives ID for one cycle, checks Stall before the edge and ID_EX after it.
// Backpressure: the table replays the stalled instruction itself, as a held IF/ID would.

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IF_ID_RegisterRs, IF_ID_RegisterRt, ID_RegisterRd;
    logic        ID_UsesRt;
    logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc;
    logic [3:0]  ID_ALUOp;
    logic        Flush, MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_RegisterRd;
    logic [31:0] WB_Data;
    logic        Stall;
    logic [4:0]  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
    logic        ID_EX_UsesRt;
    logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc;
    logic [3:0]  ID_EX_ALUOp;
    logic [15:0] StallCount, FlushCount;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .ID_RegisterRd(ID_RegisterRd), .ID_UsesRt(ID_UsesRt),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
        .Flush(Flush), .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_RegisterRd(MEM_WB_RegisterRd),
        .WB_Data(WB_Data), .Stall(Stall),
        .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
        .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_UsesRt(ID_EX_UsesRt),
        .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_Imm(ID_EX_Imm),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        uses_rt, mr, rw, flush, wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] rd1, rd2, wb_data;
        logic        e_stall, e_rw, e_mr;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic [31:0] e_rd1, e_rd2;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    vec_t vq[$];
    int   n_total  = 0;
    int   n_passed = 0;

    task automatic tv(input logic [4:0] rs, rt, rd, input logic uses_rt, mr, rw, flush, wb_we,
                      input logic [4:0] wb_rd, input logic [31:0] rd1, rd2, wb_data,
                      input logic e_stall, e_rw, e_mr, input logic [4:0] e_rs, e_rt, e_rd,
                      input logic [31:0] e_rd1, e_rd2, input logic [15:0] e_sc, e_fc);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.uses_rt = uses_rt; v.mr = mr; v.rw = rw;
        v.flush = flush; v.wb_we = wb_we; v.wb_rd = wb_rd;
        v.rd1 = rd1; v.rd2 = rd2; v.wb_data = wb_data;
        v.e_stall = e_stall; v.e_rw = e_rw; v.e_mr = e_mr;
        v.e_rs = e_rs; v.e_rt = e_rt; v.e_rd = e_rd;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_sc = e_sc; v.e_fc = e_fc;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        IF_ID_RegisterRs = '0; IF_ID_RegisterRt = '0; ID_RegisterRd = '0; ID_UsesRt = 1'b0;
        ID_ReadData1 = '0; ID_ReadData2 = '0; ID_Imm = '0;
        ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_MemWrite = 1'b0; ID_MemtoReg = 1'b0;
        ID_ALUSrc = 1'b0; ID_ALUOp = '0; Flush = 1'b0;
        MEM_WB_RegWrite = 1'b0; MEM_WB_RegisterRd = '0; WB_Data = '0;
    endtask

    function automatic logic [72:0] all_ex_outputs();
        return {ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd, ID_EX_UsesRt,
                ID_EX_ReadData1[15:0], ID_EX_ReadData2[15:0], ID_EX_Imm[15:0],
                ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
                ID_EX_ALUOp} | {57'b0, |ID_EX_ReadData1[31:16], |ID_EX_ReadData2[31:16],
                |ID_EX_Imm[31:16], 13'b0};
    endfunction

    initial begin
        vec_t        v;
        logic        bubble;
        logic [3:0]  aop;
        logic [31:0] imm;
        logic        mw;

        //  rs  rt  rd  use mr rw fl we wbrd  rd1           rd2           wb_data       | stl rw mr  ers ert erd  erd1          erd2          sc fc
        // lw $2 ; add $3,$2,$4 : one bubble, then add enters with $2 bypassed from WB
        tv(1,  2,  2,  0,  1, 1, 0, 0, 0,  32'h100,      32'h0,        32'h0,         0,  1, 1,  1,  2,  2,  32'h100,      32'h0,        0, 0);
        tv(2,  4,  3,  1,  0, 1, 0, 0, 0,  32'h11,       32'h44,       32'h0,         1,  0, 0,  0,  0,  0,  32'h0,        32'h0,        1, 0);
        tv(2,  4,  3,  1,  0, 1, 0, 1, 2,  32'h11,       32'h44,       32'h222,       0,  1, 0,  2,  4,  3,  32'h222,      32'h44,       1, 0);
        // lw $0 ; add $3,$0,$1 : no hazard on $0
        tv(1,  0,  0,  0,  1, 1, 0, 0, 0,  32'h5,        32'h0,        32'h0,         0,  1, 1,  1,  0,  0,  32'h5,        32'h0,        1, 0);
        tv(0,  1,  3,  1,  0, 1, 0, 0, 0,  32'h0,        32'h7,        32'h0,         0,  1, 0,  0,  1,  3,  32'h0,        32'h7,        1, 0);
        // lw $5 ; sw $6,0($5) with UsesRt=0 : rs match stalls
        tv(1,  5,  5,  0,  1, 1, 0, 0, 0,  32'h10,       32'h0,        32'h0,         0,  1, 1,  1,  5,  5,  32'h10,       32'h0,        1, 0);
        tv(5,  6,  0,  0,  0, 0, 0, 0, 0,  32'h50,       32'h60,       32'h0,         1,  0, 0,  0,  0,  0,  32'h0,        32'h0,        2, 0);
        tv(5,  6,  0,  0,  0, 0, 0, 0, 0,  32'h50,       32'h60,       32'h0,         0,  0, 0,  5,  6,  0,  32'h50,       32'h60,       2, 0);
        // lw $5 ; rt-only match with UsesRt=0 : no stall
        tv(1,  5,  5,  0,  1, 1, 0, 0, 0,  32'h10,       32'h0,        32'h0,         0,  1, 1,  1,  5,  5,  32'h10,       32'h0,        2, 0);
        tv(1,  5,  9,  0,  0, 1, 0, 0, 0,  32'h10,       32'h55,       32'h0,         0,  1, 0,  1,  5,  9,  32'h10,       32'h55,       2, 0);
        // lw $5 ; rt-only match with UsesRt=1 : stall
        tv(1,  5,  5,  0,  1, 1, 0, 0, 0,  32'h10,       32'h0,        32'h0,         0,  1, 1,  1,  5,  5,  32'h10,       32'h0,        2, 0);
        tv(1,  5,  9,  1,  0, 1, 0, 0, 0,  32'h10,       32'h55,       32'h0,         1,  0, 0,  0,  0,  0,  32'h0,        32'h0,        3, 0);
        tv(1,  5,  9,  1,  0, 1, 0, 0, 0,  32'h10,       32'h55,       32'h0,         0,  1, 0,  1,  5,  9,  32'h10,       32'h55,       3, 0);
        // lw $8 ; dependent add with Flush : flush wins, no stall counted
        tv(1,  8,  8,  0,  1, 1, 0, 0, 0,  32'h10,       32'h0,        32'h0,         0,  1, 1,  1,  8,  8,  32'h10,       32'h0,        3, 0);
        tv(8,  2,  3,  1,  0, 1, 1, 0, 0,  32'h88,       32'h22,       32'h0,         0,  0, 0,  0,  0,  0,  32'h0,        32'h0,        3, 1);
        // WB bypass: rs, $0 excluded, rt, WB disabled, both operands
        tv(7,  3,  10, 1,  0, 1, 0, 1, 7,  32'h0,        32'h33,       32'hDEADBEEF,  0,  1, 0,  7,  3,  10, 32'hDEADBEEF, 32'h33,       3, 1);
        tv(0,  0,  10, 1,  0, 1, 0, 1, 0,  32'h0,        32'h0,        32'hDEADBEEF,  0,  1, 0,  0,  0,  10, 32'h0,        32'h0,        3, 1);
        tv(3,  7,  11, 1,  0, 1, 0, 1, 7,  32'h33,       32'h1,        32'hCAFEF00D,  0,  1, 0,  3,  7,  11, 32'h33,       32'hCAFEF00D, 3, 1);
        tv(7,  4,  12, 1,  0, 1, 0, 0, 7,  32'h77,       32'h44,       32'h12345678,  0,  1, 0,  7,  4,  12, 32'h77,       32'h44,       3, 1);
        tv(7,  7,  13, 1,  0, 1, 0, 1, 7,  32'h1,        32'h2,        32'hAAAA5555,  0,  1, 0,  7,  7,  13, 32'hAAAA5555, 32'hAAAA5555, 3, 1);

        // Reset state
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ex_outputs", 64'(all_ex_outputs()), 64'h0);
        chk("reset_stall", 64'(Stall), 64'h0);
        chk("reset_counters", {32'h0, StallCount, FlushCount}, 64'h0);

        for (int i = 0; i < vq.size(); i++) begin
            v    = vq[i];
            aop  = 4'(i);
            imm  = 32'h1000 + 32'(i);
            mw   = !v.rw && !v.mr;
            IF_ID_RegisterRs = v.rs; IF_ID_RegisterRt = v.rt; ID_RegisterRd = v.rd;
            ID_UsesRt = v.uses_rt; ID_ReadData1 = v.rd1; ID_ReadData2 = v.rd2; ID_Imm = imm;
            ID_RegWrite = v.rw; ID_MemRead = v.mr; ID_MemWrite = mw; ID_MemtoReg = v.mr;
            ID_ALUSrc = v.mr; ID_ALUOp = aop; Flush = v.flush;
            MEM_WB_RegWrite = v.wb_we; MEM_WB_RegisterRd = v.wb_rd; WB_Data = v.wb_data;
            #1;
            chk($sformatf("v%0d_stall", i), 64'(Stall), 64'(v.e_stall));
            @(posedge clk);
            #1;
            bubble = v.e_stall || v.flush;
            chk($sformatf("v%0d_regwrite", i), 64'(ID_EX_RegWrite), 64'(v.e_rw));
            chk($sformatf("v%0d_memread", i), 64'(ID_EX_MemRead), 64'(v.e_mr));
            chk($sformatf("v%0d_regs", i), {49'h0, ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd},
                {49'h0, v.e_rs, v.e_rt, v.e_rd});
            chk($sformatf("v%0d_rd1", i), 64'(ID_EX_ReadData1), 64'(v.e_rd1));
            chk($sformatf("v%0d_rd2", i), 64'(ID_EX_ReadData2), 64'(v.e_rd2));
            chk($sformatf("v%0d_ctl_imm", i),
                64'({ID_EX_UsesRt, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_Imm}),
                bubble ? 64'h0 : 64'({v.uses_rt, mw, v.mr, v.mr, aop, imm}));
            chk($sformatf("v%0d_counts", i), {32'h0, StallCount, FlushCount}, {32'h0, v.e_sc, v.e_fc});
        end

        // Reset mid-stream while a RegWrite instruction sits in ID_EX and a hazard/flush is pending
        chk("pre_rst_regwrite", 64'(ID_EX_RegWrite), 64'h1);
        IF_ID_RegisterRs = 5'd1; IF_ID_RegisterRt = 5'd2; ID_RegisterRd = 5'd2;
        ID_MemRead = 1'b1; ID_RegWrite = 1'b1; Flush = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        Flush = 1'b0;
        #1;
        chk("midrst_ex_outputs", 64'(all_ex_outputs()), 64'h0);
        chk("midrst_stall", 64'(Stall), 64'h0);
        chk("midrst_counters", {32'h0, StallCount, FlushCount}, 64'h0);

        // FlushCount saturation: 2^16+3 flush cycles in total
        @(posedge clk);
        #1 idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        Flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1 chk("flush_cnt_65534", 64'(FlushCount), 64'hFFFE);
        @(posedge clk);
        #1 chk("flush_cnt_65535", 64'(FlushCount), 64'hFFFF);
        repeat (4) @(posedge clk);
        #1 chk("flush_cnt_saturated", 64'(FlushCount), 64'hFFFF);
        chk("stall_cnt_untouched", 64'(StallCount), 64'h0);
        chk("flush_bubble", 64'(all_ex_outputs()), 64'h0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
